// File: rtl/blackparrot_fpga_host_axil_read_arbiter.sv
// Round-robin arbiter sharing one downstream AXI-Lite read channel among MASTERS_P masters.
// One read is outstanding at a time; the response is steered back to the granted master only.
module blackparrot_fpga_host_axil_read_arbiter #(
  parameter int MASTERS_P         = 2,
  parameter int S_AXIL_ADDR_WIDTH = 64,
  parameter int S_AXIL_DATA_WIDTH = 32
) (
  input  logic                                          s_axil_aclk,
  input  logic                                          s_axil_aresetn,
  input  logic [MASTERS_P-1:0][S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [MASTERS_P-1:0][2:0]                     s_axil_arprot,
  input  logic [MASTERS_P-1:0]                          s_axil_arvalid,
  output logic [MASTERS_P-1:0]                          s_axil_arready,
  output logic [MASTERS_P-1:0][S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [MASTERS_P-1:0][1:0]                     s_axil_rresp,
  output logic [MASTERS_P-1:0]                          s_axil_rvalid,
  input  logic [MASTERS_P-1:0]                          s_axil_rready,
  output logic [S_AXIL_ADDR_WIDTH-1:0]                  m_axil_araddr,
  output logic [2:0]                                    m_axil_arprot,
  output logic                                          m_axil_arvalid,
  input  logic                                          m_axil_arready,
  input  logic [S_AXIL_DATA_WIDTH-1:0]                  m_axil_rdata,
  input  logic [1:0]                                    m_axil_rresp,
  input  logic                                          m_axil_rvalid,
  output logic                                          m_axil_rready
);

  localparam int PTR_W = (MASTERS_P > 1) ? $clog2(MASTERS_P) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               sel_q, sel_d;
  logic [PTR_W-1:0]               last_q, last_d;
  logic [S_AXIL_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [2:0]                     arprot_q, arprot_d;

  logic [PTR_W-1:0]               grant, cand;
  logic                           grant_found;
  logic                           any_req;
  logic                           ar_open, r_open;

  assign any_req = |s_axil_arvalid;

  // Search starts one past the last granted master and wraps, so the
  // most recently served master is the lowest priority.
  always_comb begin
    grant       = last_q;
    cand        = last_q;
    grant_found = 1'b0;
    for (int i = 1; i <= MASTERS_P; i++) begin
      cand = PTR_W'((int'(last_q) + i) % MASTERS_P);
      if (!grant_found && s_axil_arvalid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axil_aclk) begin
    if (!s_axil_aresetn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= PTR_W'(MASTERS_P - 1);
      araddr_q <= '0;
      arprot_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      araddr_q <= araddr_d;
      arprot_q <= arprot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    araddr_d = araddr_q;
    arprot_d = arprot_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d  = ADDR;
        sel_d    = grant;
        araddr_d = s_axil_araddr[grant];
        arprot_d = s_axil_arprot[grant];
      end
      ADDR: if (m_axil_arready) state_d = RESP;
      RESP: if (m_axil_rvalid && s_axil_rready[sel_q]) begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // arready is masked while reset is asserted so no master sees a handshake
  // that the reset is about to discard.
  always_comb begin
    ar_open        = (state_q == IDLE) && any_req && s_axil_aresetn;
    r_open         = (state_q == RESP) && m_axil_rvalid;
    m_axil_arvalid = (state_q == ADDR);
    m_axil_rready  = (state_q == RESP) && s_axil_rready[sel_q];
  end

  assign m_axil_araddr = araddr_q;
  assign m_axil_arprot = arprot_q;

  for (genvar g = 0; g < MASTERS_P; g++) begin : g_lane
    assign s_axil_arready[g] = ar_open && (grant == PTR_W'(g));
    assign s_axil_rvalid[g]  = r_open && (sel_q == PTR_W'(g));
    assign s_axil_rdata[g]   = m_axil_rdata;
    assign s_axil_rresp[g]   = m_axil_rresp;
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_read_arbiter.sv
// Bench for the AXI-Lite read arbiter: master/slave BFM plus an ordered scoreboard of
// expected reads (which master, address, data, response) in the order they must complete.
module tb_blackparrot_fpga_host_axil_read_arbiter;
  localparam int M  = 2;
  localparam int AW = 64;
  localparam int DW = 32;

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b0;
  logic [M-1:0][AW-1:0]    s_araddr  = '0;
  logic [M-1:0][2:0]       s_arprot  = '0;
  logic [M-1:0]            s_arvalid = '0;
  logic [M-1:0]            s_arready;
  logic [M-1:0][DW-1:0]    s_rdata;
  logic [M-1:0][1:0]       s_rresp;
  logic [M-1:0]            s_rvalid;
  logic [M-1:0]            s_rready  = '0;
  logic [AW-1:0]           m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_arvalid;
  logic                    m_arready = 1'b0;
  logic [DW-1:0]           m_rdata   = '0;
  logic [1:0]              m_rresp   = '0;
  logic                    m_rvalid  = 1'b0;
  logic                    m_rready;

  blackparrot_fpga_host_axil_read_arbiter #(
    .MASTERS_P(M), .S_AXIL_ADDR_WIDTH(AW), .S_AXIL_DATA_WIDTH(DW)
  ) dut (
    .s_axil_aclk(clk), .s_axil_aresetn(rst_n),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
    .s_axil_arready(s_arready), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
    .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
    .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] mq0[$];
  logic [AW-1:0] mq1[$];
  int            cmp_cnt = 0;
  int            err_cnt = 0;
  int            ar_dly = 0;
  int            r_dly = 0;
  logic [1:0]    resp_cfg = 2'b00;
  int            rr_block [M] = '{default: 0};
  int            done_cnt = 0;
  int            cyc = 0;
  int            done_cyc[$];
  int            done_m[$];

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 64'h100) return 32'hDEADBEEF;
    if (a == 64'h500) return 32'h0;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic expect_rd(input int m, input logic [AW-1:0] a, input logic [1:0] resp);
    exp_t e;
    e.m = m; e.addr = a; e.prot = a[6:4]; e.data = data_for(a); e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic enq(input int m, input logic [AW-1:0] a);
    if (m == 0) mq0.push_back(a);
    else        mq1.push_back(a);
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  // BFM: samples at negedge, drives at posedge+1; masters, slave and response monitor.
  initial begin : bfm
    logic [M-1:0]  ar_hs, r_hs, rv_seen;
    logic [M-1:0]  oh;
    logic          mar_hs, mr_hs, pend;
    logic [AW-1:0] paddr, a;
    int            arc, rc;
    exp_t          e;
    arc = 0; rc = 0; pend = 1'b0; paddr = '0;
    forever begin
      @(negedge clk);
      ar_hs   = s_arvalid & s_arready;
      r_hs    = s_rvalid & s_rready;
      rv_seen = s_rvalid;
      mar_hs  = m_arvalid && m_arready;
      mr_hs   = m_rvalid && m_rready;
      if (rst_n) begin
        cmp_cnt++;
        if ($countones(s_arready) > 1) begin
          err_cnt++;
          $display("FAIL arready_onehot: got %b, required at most one bit", s_arready);
        end
        if (|s_rvalid) begin
          cmp_cnt++;
          oh = '0;
          if (sb.size() > 0) oh[sb[0].m] = 1'b1;
          if (sb.size() == 0 || s_rvalid !== oh) begin
            err_cnt++;
            $display("FAIL rvalid_route: got %b, required %b", s_rvalid, oh);
          end
        end
        if (mar_hs) begin
          cmp_cnt++;
          paddr = m_araddr;
          if (sb.size() == 0 || m_araddr !== sb[0].addr || m_arprot !== sb[0].prot) begin
            err_cnt++;
            $display("FAIL m_ar_addr: got %h/%b, required %h/%b", m_araddr, m_arprot,
                     (sb.size() > 0) ? sb[0].addr : '0, (sb.size() > 0) ? sb[0].prot : 3'b0);
          end
        end
        for (int i = 0; i < M; i++) begin
          if (r_hs[i]) begin
            cmp_cnt++;
            done_cnt++;
            done_cyc.push_back(cyc);
            done_m.push_back(i);
            if (sb.size() == 0) begin
              err_cnt++;
              $display("FAIL rd_unexpected: got m%0d data %h, required no response", i, s_rdata[i]);
            end else begin
              e = sb.pop_front();
              if (i != e.m || s_rdata[i] !== e.data || s_rresp[i] !== e.resp) begin
                err_cnt++;
                $display("FAIL rd_result: got m%0d data %h resp %b, required m%0d data %h resp %b",
                         i, s_rdata[i], s_rresp[i], e.m, e.data, e.resp);
              end
            end
          end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0;
        arc = 0; rc = 0; pend = 1'b0;
        for (int i = 0; i < M; i++) s_rready[i] = (rr_block[i] == 0);
      end else begin
        for (int i = 0; i < M; i++) begin
          if (ar_hs[i]) s_arvalid[i] = 1'b0;
          if (!s_arvalid[i]) begin
            if (i == 0 && mq0.size() > 0) begin
              a = mq0.pop_front(); s_araddr[i] = a; s_arprot[i] = a[6:4]; s_arvalid[i] = 1'b1;
            end else if (i == 1 && mq1.size() > 0) begin
              a = mq1.pop_front(); s_araddr[i] = a; s_arprot[i] = a[6:4]; s_arvalid[i] = 1'b1;
            end
          end
          if (rv_seen[i] && rr_block[i] > 0) rr_block[i]--;
          s_rready[i] = (rr_block[i] == 0);
        end
        if (mr_hs) begin m_rvalid = 1'b0; pend = 1'b0; rc = 0; end
        if (mar_hs) begin m_arready = 1'b0; arc = 0; pend = 1'b1; rc = 0; end
        if (m_arvalid && !m_arready) begin
          if (arc >= ar_dly) m_arready = 1'b1;
          else arc++;
        end
        if (pend && !m_rvalid) begin
          if (rc >= r_dly) begin
            m_rvalid = 1'b1; m_rdata = data_for(paddr); m_rresp = resp_cfg;
          end else rc++;
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (s_arready !== '0 || s_rvalid !== '0 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_valids: got ar%b rv%b mav%b mrr%b, required all 0",
               s_arready, s_rvalid, m_arvalid, m_rready);
    end
    cmp_cnt++;
    if (m_araddr !== '0 || m_arprot !== 3'b0) begin
      err_cnt++;
      $display("FAIL reset_addr: got %h/%b, required 0/000", m_araddr, m_arprot);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_single;
    bit ok;
    bit seen;
    ar_dly = 1; r_dly = 1; resp_cfg = 2'b00;
    expect_rd(0, 64'h100, 2'b00);
    enq(0, 64'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_arready[0]) seen = 1'b1;
    end
    cmp_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL single_arready: got none, required s_arready[0]"); end
    @(negedge clk);
    cmp_cnt++;
    if (m_arvalid !== 1'b1 || m_araddr !== 64'h100) begin
      err_cnt++;
      $display("FAIL single_maddr: got v%b %h, required v1 0x100", m_arvalid, m_araddr);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_rvalid) seen = 1'b1;
    end
    cmp_cnt++;
    if (!seen || s_rvalid !== 2'b01 || s_rdata[0] !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL single_resp: got rv%b data %h, required rv01 data deadbeef", s_rvalid, s_rdata[0]);
    end
    wait_drain(40, ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL single_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_round_robin;
    bit ok;
    logic [M-1:0] first;
    ar_dly = 0; r_dly = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      expect_rd(0, 64'h10 + 64'(r * 'h20), 2'b00);
      expect_rd(1, 64'h20 + 64'(r * 'h20), 2'b00);
      enq(0, 64'h10 + 64'(r * 'h20));
      enq(1, 64'h20 + 64'(r * 'h20));
      first = '0;
      for (int i = 0; i < 20 && first == '0; i++) begin
        @(negedge clk);
        first = s_arready;
      end
      cmp_cnt++;
      if (first !== 2'b01) begin
        err_cnt++;
        $display("FAIL rr_first_grant round %0d: got %b, required 01", r, first);
      end
      wait_drain(40, ok);
      cmp_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL rr_drain: got %0d pending, required 0", sb.size()); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    bit seen;
    bit addr_bad, rr_bad, ar0_seen;
    int av_cyc, rblk;
    ar_dly = 5; r_dly = 0; rr_block[1] = 3;
    expect_rd(1, 64'h300, 2'b00);
    enq(1, 64'h300);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_arvalid) seen = 1'b1;
    end
    expect_rd(0, 64'h040, 2'b00);
    enq(0, 64'h040);
    av_cyc = seen ? 1 : 0; rblk = 0; addr_bad = 1'b0; rr_bad = 1'b0; ar0_seen = 1'b0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      if (m_arvalid) begin
        av_cyc++;
        if (m_araddr !== 64'h300 || m_arprot !== 3'b000) addr_bad = 1'b1;
      end
      if (s_arready[0]) ar0_seen = 1'b1;
      if (s_rvalid[1] && !s_rready[1]) begin
        rblk++;
        if (m_rready) rr_bad = 1'b1;
      end
      if (s_rvalid[1] && s_rready[1]) break;
    end
    cmp_cnt++;
    if (av_cyc != 6 || addr_bad) begin
      err_cnt++;
      $display("FAIL stall_ar: got %0d arvalid cycles unstable=%b, required 6 stable", av_cyc, addr_bad);
    end
    cmp_cnt++;
    if (rblk != 3 || rr_bad) begin
      err_cnt++;
      $display("FAIL stall_r: got %0d blocked cycles mrready_hi=%b, required 3 with m_rready 0", rblk, rr_bad);
    end
    cmp_cnt++;
    if (ar0_seen) begin
      err_cnt++;
      $display("FAIL stall_m0_grant: got grant to m0 mid-transaction, required none");
    end
    wait_drain(40, ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL stall_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    logic [M-1:0] first;
    ar_dly = 0; r_dly = 0; rr_block[0] = 50;
    expect_rd(0, 64'h600, 2'b00);
    enq(0, 64'h600);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_rvalid[0] && m_rvalid) seen = 1'b1;
    end
    cmp_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL rstmid_resp: got no rvalid, required rvalid in RESP"); end
    @(posedge clk); #2;
    rst_n = 1'b0; rr_block[0] = 0;
    sb.delete(); mq0.delete(); mq1.delete();
    @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (s_arready !== '0 || s_rvalid !== '0 || m_arvalid !== 1'b0 || m_rready !== 1'b0 ||
        m_araddr !== '0) begin
      err_cnt++;
      $display("FAIL rstmid_outputs: got ar%b rv%b mav%b mrr%b addr %h, required all 0",
               s_arready, s_rvalid, m_arvalid, m_rready, m_araddr);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    expect_rd(0, 64'h700, 2'b00);
    expect_rd(1, 64'h710, 2'b00);
    enq(0, 64'h700);
    enq(1, 64'h710);
    first = '0;
    for (int i = 0; i < 20 && first == '0; i++) begin
      @(negedge clk);
      first = s_arready;
    end
    cmp_cnt++;
    if (first !== 2'b01) begin
      err_cnt++;
      $display("FAIL rstmid_priority: got %b, required 01", first);
    end
    wait_drain(40, ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL rstmid_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_slverr;
    bit ok;
    bit seen;
    ar_dly = 0; r_dly = 1; resp_cfg = 2'b10;
    expect_rd(1, 64'h500, 2'b10);
    enq(1, 64'h500);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_rvalid) seen = 1'b1;
    end
    cmp_cnt++;
    if (!seen || s_rvalid !== 2'b10 || s_rresp[1] !== 2'b10 || s_rdata[1] !== 32'h0) begin
      err_cnt++;
      $display("FAIL slverr: got rv%b resp %b data %h, required rv10 resp 10 data 0",
               s_rvalid, s_rresp[1], s_rdata[1]);
    end
    wait_drain(40, ok);
    cmp_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL slverr_drain: got %0d pending, required 0", sb.size()); end
    resp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int base;
    ar_dly = 0; r_dly = 0;
    done_cyc.delete(); done_m.delete();
    for (int k = 0; k < 4; k++) begin
      expect_rd(0, 64'h800 + 64'(k * 'h10), 2'b00);
      enq(0, 64'h800 + 64'(k * 'h10));
    end
    wait_drain(60, ok);
    cmp_cnt++;
    if (!ok || done_cyc.size() != 4) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d completions, required 4", done_cyc.size());
    end
    for (int k = 1; k < done_cyc.size(); k++) begin
      cmp_cnt++;
      if (done_cyc[k] - done_cyc[k-1] != 3) begin
        err_cnt++;
        $display("FAIL b2b_spacing %0d: got %0d cycles, required 3", k, done_cyc[k] - done_cyc[k-1]);
      end
    end
    // Master 1 raised after the first completion: it must take the very next slot.
    done_m.delete();
    expect_rd(0, 64'h900, 2'b00);
    expect_rd(0, 64'h910, 2'b00);
    expect_rd(1, 64'hA00, 2'b00);
    expect_rd(0, 64'h920, 2'b00);
    expect_rd(0, 64'h930, 2'b00);
    for (int k = 0; k < 4; k++) enq(0, 64'h900 + 64'(k * 'h10));
    base = done_cnt;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (done_cnt > base) break;
    end
    enq(1, 64'hA00);
    wait_drain(60, ok);
    cmp_cnt++;
    if (!ok || done_m.size() != 5 || done_m[2] != 1) begin
      err_cnt++;
      $display("FAIL b2b_m1_slot: got %0d completions m1 at slot %0d, required 5 with m1 at slot 2",
               done_m.size(), (done_m.size() > 2) ? done_m[2] : -1);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_slverr();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
